// File: rtl/ball_pkg.sv
// Shared constants for the ball frame writer and the display peripheral:
// table limits, words per ball and the register address layout.
package ball_pkg;
   localparam int NBALLS_MAX     = 10;
   localparam int WORDS_PER_BALL = 3;
   localparam int IDX_W          = $clog2(NBALLS_MAX);
   localparam int ADDR_W         = 5;
   localparam int DATA_W         = 17;

   localparam logic [1:0] WORD_X    = 2'd0;
   localparam logic [1:0] WORD_Y    = 2'd1;
   localparam logic [1:0] WORD_SIZE = 2'd2;

   typedef enum logic {ST_IDLE, ST_WRITE} state_e;

   // Register word address of field 'word' of ball 'idx'.
   function automatic logic [ADDR_W-1:0] reg_addr(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0]       word);
      return ADDR_W'(int'(idx) * WORDS_PER_BALL + int'(word));
   endfunction
endpackage

// File: rtl/ball_frame_writer_if.sv
// Avalon-MM write bus from the frame writer to the display register file.
interface ball_frame_writer_if;
   import ball_pkg::*;
   logic [ADDR_W-1:0] avm_address;
   logic [DATA_W-1:0] avm_writedata;
   logic              avm_write;
   logic              avm_chipselect;
   logic              avm_waitrequest;

   modport master (output avm_address, avm_writedata, avm_write, avm_chipselect,
                   input  avm_waitrequest);
   modport slave  (input  avm_address, avm_writedata, avm_write, avm_chipselect,
                   output avm_waitrequest);
endinterface

// File: rtl/ball_dirty_scan.sv
// Priority encoder: lowest set dirty bit at or above start_i, or none_o.
module ball_dirty_scan
   import ball_pkg::*;
#(
   parameter int N = 10
) (
   input  logic [N-1:0]     dirty_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             none_o
);
   always_comb begin
      idx_o  = '0;
      none_o = 1'b1;
      // Descending walk so the lowest qualifying index is the last assignment.
      for (int i = N - 1; i >= 0; i--) begin
         if (dirty_i[i] && (IDX_W'(i) >= start_i)) begin
            idx_o  = IDX_W'(i);
            none_o = 1'b0;
         end
      end
   end
endmodule

// File: rtl/ball_frame_writer.sv
// Shadow table of ball positions; on each VGA vsync fall, bursts the dirty
// entries into the display registers over Avalon-MM.
module ball_frame_writer
   import ball_pkg::*;
#(
   parameter int NBALLS = 10,
   parameter int DW     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [IDX_W-1:0]     load_idx,
   input  logic [DW-1:0]        load_x,
   input  logic [DW-1:0]        load_y,
   input  logic [DW-1:0]        load_size,
   input  logic                 vga_vs,
   ball_frame_writer_if.master  avm,
   output logic                 busy,
   output logic [15:0]          frames_written,
   output logic                 bad_idx
);
   state_e                    state_q, state_d;
   logic [NBALLS-1:0][DW-1:0] x_q, y_q, size_q;
   logic [NBALLS-1:0]         dirty_q, load_mask, scan_vec;
   logic [IDX_W-1:0]          ball_q, ball_d, scan_start, scan_idx;
   logic [1:0]                word_q, word_d;
   logic [15:0]               frames_q, frames_d;
   logic                      vs_q, vs_fall, bad_idx_q;
   logic                      load_acc, idx_ok, scan_none, wr, word_done, last_word;
   logic [DW-1:0]             field;

   assign load_ready = (state_q == ST_IDLE);
   assign load_acc   = load_valid && load_ready;
   assign idx_ok     = (load_idx < IDX_W'(NBALLS));
   assign vs_fall    = vs_q && !vga_vs;
   assign wr         = (state_q == ST_WRITE);
   assign word_done  = wr && !avm.avm_waitrequest;
   assign last_word  = word_done && (word_q == WORD_SIZE);

   always_comb begin
      for (int k = 0; k < NBALLS; k++)
         load_mask[k] = load_acc && (load_idx == IDX_W'(k));
   end

   // IDLE: include a same-cycle load in the search. WRITE: look past current ball.
   assign scan_vec   = wr ? dirty_q : (dirty_q | load_mask);
   assign scan_start = wr ? ball_q + IDX_W'(1) : '0;

   ball_dirty_scan #(.N(NBALLS)) u_scan (
      .dirty_i (scan_vec),
      .start_i (scan_start),
      .idx_o   (scan_idx),
      .none_o  (scan_none)
   );

   always_comb begin
      state_d  = state_q;
      ball_d   = ball_q;
      word_d   = word_q;
      frames_d = frames_q;
      case (state_q)
         ST_IDLE: if (vs_fall && !scan_none) begin
            state_d = ST_WRITE;
            ball_d  = scan_idx;
            word_d  = WORD_X;
         end
         ST_WRITE: if (last_word) begin
            word_d = WORD_X;
            if (scan_none) begin
               state_d  = ST_IDLE;
               ball_d   = '0;
               frames_d = frames_q + 16'd1;
            end else begin
               ball_d = scan_idx;
            end
         end else if (word_done) begin
            word_d = word_q + 2'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         ball_q    <= '0;
         word_q    <= '0;
         frames_q  <= '0;
         vs_q      <= 1'b1;
         bad_idx_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ball_q    <= ball_d;
         word_q    <= word_d;
         frames_q  <= frames_d;
         vs_q      <= vga_vs;
         bad_idx_q <= bad_idx_q | (load_acc && !idx_ok);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q     <= '0;
         y_q     <= '0;
         size_q  <= '0;
         dirty_q <= '0;
      end else begin
         for (int k = 0; k < NBALLS; k++) begin
            if (load_mask[k]) begin
               x_q[k]     <= load_x;
               y_q[k]     <= load_y;
               size_q[k]  <= load_size;
               dirty_q[k] <= 1'b1;
            end else if (last_word && (ball_q == IDX_W'(k))) begin
               dirty_q[k] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      field = '0;
      if (wr) begin
         case (word_q)
            WORD_X:    field = x_q[ball_q];
            WORD_Y:    field = y_q[ball_q];
            WORD_SIZE: field = size_q[ball_q];
            default:   field = '0;
         endcase
      end
   end

   assign avm.avm_write      = wr;
   assign avm.avm_chipselect = wr;
   assign avm.avm_address    = wr ? reg_addr(ball_q, word_q) : '0;
   assign avm.avm_writedata  = DATA_W'(field);

   assign busy           = wr;
   assign frames_written = frames_q;
   assign bad_idx        = bad_idx_q;
endmodule

// File: tb/tb_ball_frame_writer.sv
// Directed bench for ball_frame_writer: logs completed Avalon words and
// compares them against hand-computed bursts.
module tb_ball_frame_writer;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        load_valid, load_ready, vga_vs;
   logic [3:0]  load_idx;
   logic [15:0] load_x, load_y, load_size;
   logic        busy, bad_idx;
   logic [15:0] frames_written;

   ball_frame_writer_if avm ();

   ball_frame_writer #(.NBALLS(10), .DW(16)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .load_idx       (load_idx),
      .load_x         (load_x),
      .load_y         (load_y),
      .load_size      (load_size),
      .vga_vs         (vga_vs),
      .avm            (avm),
      .busy           (busy),
      .frames_written (frames_written),
      .bad_idx        (bad_idx)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int vs_cyc;
   int addr0_cnt;
   int log_a[$], log_d[$], log_c[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (reset_n && avm.avm_write && avm.avm_address == 5'd0) addr0_cnt++;
      if (reset_n && avm.avm_write && !avm.avm_waitrequest) begin
         log_a.push_back(int'(avm.avm_address));
         log_d.push_back(int'(avm.avm_writedata));
         log_c.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_word(input string tag, input int i, input int a, input int d);
      chk($sformatf("%s_addr%0d", tag, i), (i < log_a.size()) ? log_a[i] : -1, a);
      chk($sformatf("%s_data%0d", tag, i), (i < log_d.size()) ? log_d[i] : -1, d);
   endtask

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
      log_c.delete();
   endtask

   task automatic load(input int idx, input int x, input int y, input int s);
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_idx   = 4'(idx);
      load_x     = 16'(x);
      load_y     = 16'(y);
      load_size  = 16'(s);
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   // Returns one tick into the first cycle after the vs_fall cycle.
   task automatic vs_pulse();
      @(posedge clk); #1;
      vga_vs = 1'b0;
      @(negedge clk);
      vs_cyc = cyc;
      @(posedge clk); #1;
      vga_vs = 1'b1;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk({tag, "_idle"}, int'(busy), 0);
   endtask

   initial begin
      reset_n    = 1'b0;
      load_valid = 1'b0;
      load_idx   = '0;
      load_x     = '0;
      load_y     = '0;
      load_size  = '0;
      vga_vs     = 1'b1;
      avm.avm_waitrequest = 1'b0;
      addr0_cnt  = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_write",  int'(avm.avm_write), 0);
      chk("rst_cs",     int'(avm.avm_chipselect), 0);
      chk("rst_addr",   int'(avm.avm_address), 0);
      chk("rst_data",   int'(avm.avm_writedata), 0);
      chk("rst_busy",   int'(busy), 0);
      chk("rst_frames", int'(frames_written), 0);
      chk("rst_bad",    int'(bad_idx), 0);
      chk("rst_ready",  int'(load_ready), 1);

      // Single ball, no stall
      clear_log();
      load(2, 320, 240, 25);
      vs_pulse();
      chk("t1_ready_low", int'(load_ready), 0);
      wait_idle("t1", 20);
      chk("t1_count", log_a.size(), 3);
      chk_word("t1", 0, 6, 320);
      chk_word("t1", 1, 7, 240);
      chk_word("t1", 2, 8, 25);
      chk("t1_first_cyc", (log_c.size() > 0) ? log_c[0] - vs_cyc : -1, 1);
      chk("t1_b2b_1", (log_c.size() > 2) ? log_c[1] - log_c[0] : -1, 1);
      chk("t1_b2b_2", (log_c.size() > 2) ? log_c[2] - log_c[1] : -1, 1);
      chk("t1_frames", int'(frames_written), 1);
      chk("t1_addr_idle", int'(avm.avm_address), 0);

      // Balls 0 and 9, first word stalled three cycles
      clear_log();
      load(0, 11, 12, 13);
      load(9, 91, 92, 93);
      avm.avm_waitrequest = 1'b1;
      addr0_cnt = 0;
      vs_pulse();
      @(negedge clk);
      chk("t2_stall_wr",   int'(avm.avm_write), 1);
      chk("t2_stall_cs",   int'(avm.avm_chipselect), 1);
      chk("t2_stall_addr", int'(avm.avm_address), 0);
      chk("t2_stall_data", int'(avm.avm_writedata), 11);
      repeat (3) @(posedge clk);
      #1 avm.avm_waitrequest = 1'b0;
      wait_idle("t2", 30);
      chk("t2_addr0_hold", addr0_cnt, 4);
      chk("t2_count", log_a.size(), 6);
      chk_word("t2", 0, 0, 11);
      chk_word("t2", 1, 1, 12);
      chk_word("t2", 2, 2, 13);
      chk_word("t2", 3, 27, 91);
      chk_word("t2", 4, 28, 92);
      chk_word("t2", 5, 29, 93);
      chk("t2_frames", int'(frames_written), 2);

      // Out-of-range index, then a vsync with nothing dirty
      clear_log();
      load(12, 1, 2, 3);
      @(negedge clk);
      chk("t3_bad", int'(bad_idx), 1);
      repeat (3) @(negedge clk);
      chk("t3_bad_sticky", int'(bad_idx), 1);
      vs_pulse();
      repeat (5) @(negedge clk);
      chk("t3_no_writes", log_a.size(), 0);
      chk("t3_frames", int'(frames_written), 2);
      chk("t3_busy", int'(busy), 0);

      // Load accepted in the same cycle as the vsync fall
      clear_log();
      @(posedge clk); #1;
      load_valid = 1'b1;
      load_idx   = 4'd4;
      load_x     = 16'd40;
      load_y     = 16'd41;
      load_size  = 16'd42;
      vga_vs     = 1'b0;
      @(negedge clk);
      vs_cyc = cyc;
      @(posedge clk); #1;
      load_valid = 1'b0;
      vga_vs     = 1'b1;
      wait_idle("t4", 20);
      chk("t4_count", log_a.size(), 3);
      chk_word("t4", 0, 12, 40);
      chk_word("t4", 1, 13, 41);
      chk_word("t4", 2, 14, 42);
      chk("t4_first_cyc", (log_c.size() > 0) ? log_c[0] - vs_cyc : -1, 1);
      chk("t4_frames", int'(frames_written), 3);
      chk("t4_bad_sticky", int'(bad_idx), 1);

      // Reset during the second word of a burst
      load(1, 100, 101, 102);
      vs_pulse();
      @(posedge clk); #1;
      chk("t5_second_addr", int'(avm.avm_address), 4);
      #1 reset_n = 1'b0;
      #1;
      chk("t5_rst_write",  int'(avm.avm_write), 0);
      chk("t5_rst_cs",     int'(avm.avm_chipselect), 0);
      chk("t5_rst_busy",   int'(busy), 0);
      chk("t5_rst_frames", int'(frames_written), 0);
      chk("t5_rst_bad",    int'(bad_idx), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      clear_log();
      repeat (5) @(negedge clk);
      chk("t5_quiet", log_a.size(), 0);
      vs_pulse();
      repeat (5) @(negedge clk);
      chk("t5_vs_no_dirty", log_a.size(), 0);
      chk("t5_frames0", int'(frames_written), 0);
      load(5, 50, 51, 52);
      vs_pulse();
      wait_idle("t5", 20);
      chk("t5_count", log_a.size(), 3);
      chk_word("t5", 0, 15, 50);
      chk_word("t5", 2, 17, 52);
      chk("t5_frames1", int'(frames_written), 1);

      // Second vsync fall during a stalled burst
      clear_log();
      load(7, 70, 71, 72);
      avm.avm_waitrequest = 1'b1;
      vs_pulse();
      @(posedge clk); #1 vga_vs = 1'b0;
      @(posedge clk); #1 vga_vs = 1'b1;
      @(posedge clk); #1 avm.avm_waitrequest = 1'b0;
      wait_idle("t6", 30);
      repeat (5) @(negedge clk);
      chk("t6_count", log_a.size(), 3);
      chk_word("t6", 0, 21, 70);
      chk_word("t6", 1, 22, 71);
      chk_word("t6", 2, 23, 72);
      chk("t6_frames", int'(frames_written), 2);
      chk("t6_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
